dbg_mem_port: RTL and testbench

Memory-side responder for the debug unit's memory port and the picorv32 native memory interface. Arbitrates between the two initiators (debug has priority) and serves both from one word-addressed on-chip RAM. mem_rdy / mem_ready is returned as a single-cycle pulse with read data valid in the same cycle. Sits between dbgu32, picorv32 and block RAM in the SoC top level.

---
 rtl/dbg_mem_port_pkg.sv | 8 +
 rtl/dbg_mem_port_if.sv | 27 ++
 rtl/dbg_mem_port_bram32_be.sv | 21 ++
 rtl/dbg_mem_port.sv | 70 +++++++
 tb/tb_dbg_mem_port.sv | 115 +++++++++++
 5 files changed

// File: rtl/dbg_mem_port_pkg.sv
// dbg_mem_port_pkg: shared FSM encodings and byte-enable constants for dbg_mem_port.
package dbg_mem_port_pkg;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [3:0] BE_ALL   = 4'b1111;
    localparam logic [3:0] BE_NONE  = 4'b0000;
endpackage

// File: rtl/dbg_mem_port_if.sv
// dbg_mem_port_if: debug-unit and picorv32 memory request/response signals.
interface dbg_mem_port_if;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
    logic        dbg_rw;
    logic        dbg_mem_op;
    logic        dbg_mem_rdy;
    logic        cpu_mem_valid;
    logic        cpu_mem_instr;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic [31:0] cpu_mem_rdata;
    logic        cpu_mem_ready;
    logic        grant_dbg;
    modport master (
        output dbg_adr, dbg_wdata, dbg_rw, dbg_mem_op,
        output cpu_mem_valid, cpu_mem_instr, cpu_mem_addr, cpu_mem_wdata, cpu_mem_wstrb,
        input  dbg_rdata, dbg_mem_rdy, cpu_mem_rdata, cpu_mem_ready, grant_dbg
    );
    modport slave (
        input  dbg_adr, dbg_wdata, dbg_rw, dbg_mem_op,
        input  cpu_mem_valid, cpu_mem_instr, cpu_mem_addr, cpu_mem_wdata, cpu_mem_wstrb,
        output dbg_rdata, dbg_mem_rdy, cpu_mem_rdata, cpu_mem_ready, grant_dbg
    );
endinterface

// File: rtl/dbg_mem_port_bram32_be.sv
// bram32_be: single-port synchronous 32-bit RAM with byte enables, 1-cycle read latency.
module bram32_be #(
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++)
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/dbg_mem_port.sv
// dbg_mem_port: debug-priority arbiter serving dbgu32 and picorv32 from one block RAM.
module dbg_mem_port
    import dbg_mem_port_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = ""
) (
    input logic           clk,
    input logic           reset,
    dbg_mem_port_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [1:0]    state_q, state_d;
    logic          gnt_q, gnt_d, oor_q, oor_d;
    logic [AW-1:0] widx_q, widx_d;
    logic [31:0]   wdata_q, wdata_d, dbg_rdata_q, dbg_rdata_d, cpu_rdata_q, cpu_rdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   ram_rdata, req_addr, rd_word;
    logic          req, grant, resp, rd, unused_ok;
    assign req      = bus.dbg_mem_op | bus.cpu_mem_valid;
    assign grant    = state_q == S_IDLE && req;
    assign req_addr = bus.dbg_mem_op ? bus.dbg_adr : bus.cpu_mem_addr;
    assign resp     = state_q == S_RESP && !reset;
    assign rd       = be_q == BE_NONE;
    assign rd_word  = oor_q ? 32'h0 : ram_rdata;
    assign unused_ok = ^{bus.cpu_mem_instr, req_addr[1:0]};
    always_comb begin
        state_d     = state_q == S_IDLE ? (req ? S_ACCESS : S_IDLE) : state_q == S_ACCESS ? S_RESP : S_IDLE;
        gnt_d       = grant ? bus.dbg_mem_op : gnt_q;
        widx_d      = grant ? req_addr[AW+1:2] : widx_q;
        oor_d       = grant ? |req_addr[31:AW+2] : oor_q;
        wdata_d     = grant ? (bus.dbg_mem_op ? bus.dbg_wdata : bus.cpu_mem_wdata) : wdata_q;
        be_d        = grant ? (bus.dbg_mem_op ? (bus.dbg_rw ? BE_NONE : BE_ALL) : bus.cpu_mem_wstrb) : be_q;
        dbg_rdata_d = resp && rd && gnt_q ? rd_word : dbg_rdata_q;
        cpu_rdata_d = resp && rd && !gnt_q ? rd_word : cpu_rdata_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= 1'b0;
            dbg_rdata_q <= 32'h0;
            cpu_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end
    always_ff @(posedge clk) begin
        widx_q  <= widx_d;
        oor_q   <= oor_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end
    // Out-of-range writes are dropped here; reads of them are zeroed via rd_word.
    bram32_be #(.DEPTH(DEPTH), .INIT_FILE(INIT_FILE)) u_ram (
        .clk   (clk),
        .en    (state_q == S_ACCESS),
        .we    (state_q == S_ACCESS && !oor_q ? be_q : BE_NONE),
        .addr  (widx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );
    assign bus.dbg_rdata     = dbg_rdata_d;
    assign bus.cpu_mem_rdata = cpu_rdata_d;
    assign bus.dbg_mem_rdy   = resp && gnt_q;
    assign bus.cpu_mem_ready = resp && !gnt_q;
    assign bus.grant_dbg     = gnt_q;
endmodule

// File: tb/tb_dbg_mem_port.sv
// tb_dbg_mem_port: directed checks of arbitration, timing, byte masks, range and reset.
module tb_dbg_mem_port;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vec = 0;
    int errs = 0;
    dbg_mem_port_if bus ();
    dbg_mem_port #(.DEPTH(1024), .INIT_FILE("")) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(negedge clk);
    endtask
    task automatic issue(input bit d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        if (d) begin
            bus.dbg_adr = a; bus.dbg_wdata = wd; bus.dbg_rw = (st == 4'b0000); bus.dbg_mem_op = 1'b1;
        end else begin
            bus.cpu_mem_addr = a; bus.cpu_mem_wdata = wd; bus.cpu_mem_wstrb = st; bus.cpu_mem_valid = 1'b1;
        end
    endtask
    task automatic drop;
        bus.dbg_mem_op = 1'b0;
        bus.cpu_mem_valid = 1'b0;
    endtask
    task automatic xact(input string tag, input bit d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input bit rd_chk, input logic [31:0] exp);
        issue(d, a, wd, st);
        chk({tag, " rdy c0"}, 32'(d ? bus.dbg_mem_rdy : bus.cpu_mem_ready), 32'd0);
        tick;
        chk({tag, " rdy c1"}, 32'(d ? bus.dbg_mem_rdy : bus.cpu_mem_ready), 32'd0);
        tick;
        chk({tag, " rdy c2"}, 32'(d ? bus.dbg_mem_rdy : bus.cpu_mem_ready), 32'd1);
        chk({tag, " other rdy c2"}, 32'(d ? bus.cpu_mem_ready : bus.dbg_mem_rdy), 32'd0);
        chk({tag, " grant"}, 32'(bus.grant_dbg), 32'(d));
        if (rd_chk) chk({tag, " rdata"}, d ? bus.dbg_rdata : bus.cpu_mem_rdata, exp);
        drop;
        tick;
        chk({tag, " rdy c3"}, 32'(d ? bus.dbg_mem_rdy : bus.cpu_mem_ready), 32'd0);
    endtask
    initial begin
        bus.dbg_adr = '0; bus.dbg_wdata = '0; bus.dbg_rw = 1'b1; bus.dbg_mem_op = 1'b0;
        bus.cpu_mem_valid = 1'b0; bus.cpu_mem_instr = 1'b0; bus.cpu_mem_addr = '0;
        bus.cpu_mem_wdata = '0; bus.cpu_mem_wstrb = '0;
        tick;
        tick;
        chk("rst dbg_rdata", bus.dbg_rdata, 32'h0);
        chk("rst cpu_rdata", bus.cpu_mem_rdata, 32'h0);
        chk("rst dbg_rdy", 32'(bus.dbg_mem_rdy), 32'd0);
        chk("rst cpu_ready", 32'(bus.cpu_mem_ready), 32'd0);
        chk("rst grant", 32'(bus.grant_dbg), 32'd0);
        reset = 1'b0;
        xact("dbg wr", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        xact("dbg rd", 1'b1, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF);
        xact("cpu wr full", 1'b0, 32'h20, 32'hAAAAAAAA, 4'hF, 1'b0, 32'h0);
        xact("cpu wr 0101", 1'b0, 32'h22, 32'h11223344, 4'h5, 1'b0, 32'h0);
        chk("cpu wr keeps rdata", bus.cpu_mem_rdata, 32'h0);
        xact("cpu rd", 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'hAA22AA44);
        issue(1'b1, 32'h10, 32'h0, 4'h0);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        tick;
        tick;
        chk("sim dbg_rdy c2", 32'(bus.dbg_mem_rdy), 32'd1);
        chk("sim cpu_ready c2", 32'(bus.cpu_mem_ready), 32'd0);
        chk("sim grant c2", 32'(bus.grant_dbg), 32'd1);
        chk("sim dbg_rdata", bus.dbg_rdata, 32'hDEADBEEF);
        bus.dbg_mem_op = 1'b0;
        tick;
        chk("sim grant c3", 32'(bus.grant_dbg), 32'd1);
        chk("sim cpu_ready c3", 32'(bus.cpu_mem_ready), 32'd0);
        tick;
        chk("sim grant c4", 32'(bus.grant_dbg), 32'd0);
        chk("sim cpu_ready c4", 32'(bus.cpu_mem_ready), 32'd0);
        tick;
        chk("sim cpu_ready c5", 32'(bus.cpu_mem_ready), 32'd1);
        chk("sim dbg_rdy c5", 32'(bus.dbg_mem_rdy), 32'd0);
        chk("sim cpu_rdata", bus.cpu_mem_rdata, 32'hAA22AA44);
        drop;
        tick;
        chk("sim cpu_ready c6", 32'(bus.cpu_mem_ready), 32'd0);
        xact("dbg wr idx0", 1'b1, 32'h0, 32'h12345678, 4'hF, 1'b0, 32'h0);
        xact("oor wr", 1'b1, 32'h0001_0000, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
        xact("oor rd", 1'b1, 32'h0001_0000, 32'h0, 4'h0, 1'b1, 32'h0);
        xact("rd idx0", 1'b1, 32'h0, 32'h0, 4'h0, 1'b1, 32'h12345678);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        tick;
        reset = 1'b1;
        drop;
        tick;
        chk("rst mid cpu_ready", 32'(bus.cpu_mem_ready), 32'd0);
        chk("rst mid dbg_rdy", 32'(bus.dbg_mem_rdy), 32'd0);
        chk("rst mid cpu_rdata", bus.cpu_mem_rdata, 32'h0);
        chk("rst mid dbg_rdata", bus.dbg_rdata, 32'h0);
        chk("rst mid grant", 32'(bus.grant_dbg), 32'd0);
        reset = 1'b0;
        tick;
        chk("post rst idle cpu_ready", 32'(bus.cpu_mem_ready), 32'd0);
        xact("cpu rd after rst", 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'hAA22AA44);
        issue(1'b1, 32'h10, 32'h0, 4'h0);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("held rdy c%0d", i), 32'(bus.dbg_mem_rdy), 32'(i % 3 == 2));
            if (i == 11) drop;
            tick;
        end
        chk("held rdy after drop", 32'(bus.dbg_mem_rdy), 32'd0);
        chk("held dbg_rdata", bus.dbg_rdata, 32'hDEADBEEF);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
